mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control sequencer for the RV32I core. It sits beside `alucont` and the shared datapath (one ALU, one unified memory, IR/MDR/ALUOut registers). It steps each instruction through IF/ID/EX/MEM/WB states and drives every datapath enable and mux select, including the ALU-op class consumed by `alucont`. It stalls on a memory ready handshake.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 0: 0 disables the memory-wait watchdog. N>0 forces HALT after N consecutive not-ready cycles in one memory state.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; state forced to IF.
- `opcode` input 7: IR[6:0]; valid from ID onward.
- `bcond` input 1: ALU branch-taken result; valid in EX of BRANCH.
- `halt_cond` input 1: datapath flag, x17 == 10.
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `pc_write` output 1: PC load enable.
- `pc_src` output 2: 00 PC+4 adder, 01 ALUOut register, 10 live ALU result.
- `i_or_d` output 1: memory address select, 0 PC, 1 ALUOut.
- `mem_read` output 1, `mem_write` output 1: memory strobes.
- `ir_write` output 1: IR load enable.
- `reg_write` output 1: register file write enable.
- `wb_sel` output 2: 00 ALUOut, 01 MDR, 10 PC+4.
- `alu_src_a` output 1: 0 PC, 1 rs1.
- `alu_src_b` output 2: 00 rs2, 01 constant 4, 10 immediate.
- `alu_op_sel` output 2: to `alucont`; 00 add, 01 branch-compare, 10 funct-decoded.
- `is_halted` output 1: core halted.
- `state` output 3: current state, for debug.

## Operation
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to IF next cycle with all outputs 0.
- Each state drives the listed outputs; every other output is 0.
- IF: mem_read=1, i_or_d=0.
  - ir_write=mem_ready. Go to ID on mem_ready, else stay in IF.
- ID: alu_src_a=0, alu_src_b=10, alu_op_sel=00. This latches PC+imm into ALUOut.
  - ECALL (1110011) with halt_cond, macro defined: go to HALT.
  - ECALL otherwise: pc_write=1, pc_src=00, go to IF.
  - Unknown opcode: treated as NOP, same as the second ECALL case.
  - All others: go to EX.
- EX, by opcode:
  - ARITHMETIC: alu_src_a=1, alu_src_b=00, alu_op_sel=10; go to WB.
  - ARITHMETIC_IMM: as ARITHMETIC but alu_src_b=10; go to WB.
  - LOAD or STORE: alu_src_a=1, alu_src_b=10, alu_op_sel=00; go to MEM.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op_sel=01, pc_write=1; pc_src=01 if bcond else 00; go to IF.
  - JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=01; go to IF.
  - JALR: alu_src_a=1, alu_src_b=10, alu_op_sel=00, reg_write=1, wb_sel=10, pc_write=1, pc_src=10; go to IF. The datapath clears the LSB.
- MEM: i_or_d=1, with mem_read=1 for LOAD or mem_write=1 for STORE. Wait until mem_ready.
  - LOAD goes to WB.
  - STORE sets pc_write=1, pc_src=00 in the ready cycle and goes to IF.
- WB: reg_write=1, pc_write=1, pc_src=00; wb_sel=01 for LOAD, else 00; go to IF.
- HALT: is_halted=1, all other outputs 0. Stays in HALT until reset.
- Watchdog (MEM_TIMEOUT>0): a counter counts consecutive not-ready cycles in IF or MEM and clears on state change. When it reaches MEM_TIMEOUT, the FSM goes to HALT.

## Timing
- The state register is the only state besides the watchdog counter.
- Outputs are combinational from state, opcode, bcond and mem_ready. ir_write, pc_write (BRANCH, STORE) and the transitions are Mealy terms.
- While reset is high: all outputs 0, is_halted=0, state=IF, counter=0. The first IF cycle is the cycle after reset deasserts.
- Reset asserted mid-instruction aborts it immediately; no partial write may occur after the reset edge.
- Latency with zero-wait memory, in cycles:
  - ARITHMETIC / ARITHMETIC_IMM: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH, JAL, JALR: 3.
  - ECALL / NOP: 2.
- Each cycle with mem_ready=0 in IF or MEM adds one cycle. Memory strobes and i_or_d stay stable throughout the wait.
- mem_ready outside IF/MEM is ignored.

## Configuration
- `ECALL_HALT_EN` defined: ECALL with halt_cond=1 goes to HALT.
- Macro undefined: every ECALL is a 2-cycle NOP. is_halted is only set by the watchdog.

## Test plan
- Reset, then ADD with mem_ready=1 -> states 0,1,2,4,0. reg_write=1 only in WB with wb_sel=00. pc_write once.
- LOAD with mem_ready low for 3 cycles in MEM -> mem_read and i_or_d=1 held for 4 cycles, then WB with wb_sel=01. Total 8 cycles.
- BEQ with bcond=1, then BEQ with bcond=0 -> in EX, pc_src=01 then 00 respectively, pc_write=1 both times. 3 cycles each.
- JALR -> EX asserts reg_write=1, wb_sel=10, pc_src=10, alu_src_b=10.
- ECALL with halt_cond=1 -> is_halted=1 from the cycle after ID and held for 100 cycles with `ECALL_HALT_EN` defined. Without the macro, back to IF after 2 cycles.
- Reset asserted during STORE MEM wait -> mem_write drops to 0 at once and state=0. MEM_TIMEOUT=5 with mem_ready stuck low -> HALT after 5 IF cycles.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control sequencer for the RV32I core.
// Steps each instruction through IF/ID/EX/MEM/WB and drives every datapath
// enable and mux select, stalling on the memory ready handshake.
// Optional feature macro: ECALL_HALT_EN (ECALL with halt_cond halts the core).
// MEM_TIMEOUT > 0 enables a watchdog that halts after that many consecutive
// not-ready cycles spent in one memory state.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op_sel,
  output logic       is_halted,
  output logic [2:0] state
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          ecall_halt;

`ifdef ECALL_HALT_EN
  assign ecall_halt = halt_cond;
`else
  // Without the halt feature halt_cond has no effect; every ECALL is a NOP.
  logic unused_halt_cond;
  assign unused_halt_cond = halt_cond;
  assign ecall_halt       = 1'b0;
`endif

  assign state = state_q;

  // State register and watchdog counter; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and Mealy outputs; everything held at 0 while reset is high so
  // no strobe or write enable survives the reset edge.
  always_comb begin
    state_d    = state_q;
    wd_d       = '0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op_sel = 2'b00;
    is_halted  = 1'b0;

    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          if (mem_ready) state_d = S_ID;
        end

        S_ID: begin
          // PC + imm goes into ALUOut for a later branch/JAL target.
          alu_src_b = 2'b10;
          case (opcode)
            OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
            default: begin
              if (opcode == OP_ECALL && ecall_halt) begin
                state_d = S_HALT;
              end else begin
                // ECALL or unknown opcode retires as a NOP.
                pc_write = 1'b1;
                state_d  = S_IF;
              end
            end
          endcase
        end

        S_EX: begin
          state_d = S_IF;
          case (opcode)
            OP_ARITH: begin
              alu_src_a  = 1'b1;
              alu_op_sel = 2'b10;
              state_d    = S_WB;
            end
            OP_ARITH_IMM: begin
              alu_src_a  = 1'b1;
              alu_src_b  = 2'b10;
              alu_op_sel = 2'b10;
              state_d    = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              state_d   = S_MEM;
            end
            OP_BRANCH: begin
              alu_src_a  = 1'b1;
              alu_op_sel = 2'b01;
              pc_write   = 1'b1;
              pc_src     = bcond ? 2'b01 : 2'b00;
            end
            OP_JAL: begin
              reg_write = 1'b1;
              wb_sel    = 2'b10;
              pc_write  = 1'b1;
              pc_src    = 2'b01;
            end
            OP_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              reg_write = 1'b1;
              wb_sel    = 2'b10;
              pc_write  = 1'b1;
              pc_src    = 2'b10;
            end
            default: ;
          endcase
        end

        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (opcode == OP_LOAD);
          mem_write = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_LOAD) begin
              state_d = S_WB;
            end else begin
              pc_write = 1'b1;
              state_d  = S_IF;
            end
          end
        end

        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          wb_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
          state_d   = S_IF;
        end

        S_HALT: is_halted = 1'b1;

        default: state_d = S_IF;
      endcase

      // Watchdog: consecutive not-ready cycles in one memory state; the
      // default wd_d of 0 clears it on every state change.
      if (MEM_TIMEOUT > 0 && (state_q == S_IF || state_q == S_MEM) && !mem_ready) begin
        if (wd_q == CW'(MEM_TIMEOUT - 1)) state_d = S_HALT;
        else                              wd_d    = wd_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: one default instance plus a second one
// with MEM_TIMEOUT=5 and memory never ready, for the watchdog.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset, bcond, halt_cond, mem_ready;
  logic [6:0] opcode;
  logic       mem_ready2;

  logic       pc_write, mem_read, mem_write, ir_write, reg_write, i_or_d, alu_src_a, is_halted;
  logic [1:0] pc_src, wb_sel, alu_src_b, alu_op_sel;
  logic [2:0] state;

  logic       w_pc_write, w_mem_read, w_mem_write, w_ir_write, w_reg_write, w_i_or_d, w_alu_src_a, w_is_halted;
  logic [1:0] w_pc_src, w_wb_sel, w_alu_src_b, w_alu_op_sel;
  logic [2:0] w_state;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .is_halted(is_halted), .state(state)
  );

  mc_control_fsm #(.MEM_TIMEOUT(5)) dut_wd (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
    .mem_ready(mem_ready2), .pc_write(w_pc_write), .pc_src(w_pc_src), .i_or_d(w_i_or_d),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write), .reg_write(w_reg_write),
    .wb_sel(w_wb_sel), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op_sel(w_alu_op_sel),
    .is_halted(w_is_halted), .state(w_state)
  );

  wire [15:0] outv = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_write,
                      wb_sel, alu_src_a, alu_src_b, alu_op_sel, is_halted};
  wire [15:0] w_outv = {w_pc_write, w_pc_src, w_i_or_d, w_mem_read, w_mem_write, w_ir_write, w_reg_write,
                        w_wb_sel, w_alu_src_a, w_alu_src_b, w_alu_op_sel, w_is_halted};

  // Expected output vector, fields in the same order as outv.
  function automatic logic [15:0] ov(input logic pcw, input logic [1:0] pcs, input logic iod,
                                     input logic mr, input logic mw, input logic irw, input logic rw,
                                     input logic [1:0] wbs, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic hlt);
    return {pcw, pcs, iod, mr, mw, irw, rw, wbs, asa, asb, aop, hlt};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs already set: settle, check state and outputs, then advance one cycle.
  task automatic step(input string tag, input logic [2:0] st, input logic [15:0] o);
    #1;
    chk({tag, ".state"}, {13'd0, state}, {13'd0, st});
    chk({tag, ".out"}, outv, o);
    @(posedge clk); #1;
  endtask

  logic [15:0] O_ZERO, O_IF_R, O_IF_W, O_ID, O_NOP, O_EX_R, O_EX_I, O_EX_M, O_WB_A, O_WB_L;
  logic [15:0] O_MEM_L, O_MEM_SW, O_MEM_SR, O_BR_T, O_BR_N, O_JAL, O_JALR, O_HALT;

  initial begin
    O_ZERO   = 16'h0000;
    O_IF_R   = ov(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    O_IF_W   = ov(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    O_ID     = ov(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 2'd0, 1'b0);
    O_NOP    = ov(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 2'd0, 1'b0);
    O_EX_R   = ov(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd2, 1'b0);
    O_EX_I   = ov(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b0);
    O_EX_M   = ov(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd0, 1'b0);
    O_WB_A   = ov(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    O_WB_L   = ov(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0);
    O_MEM_L  = ov(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    O_MEM_SW = ov(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    O_MEM_SR = ov(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    O_BR_T   = ov(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    O_BR_N   = ov(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    O_JAL    = ov(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0);
    O_JALR   = ov(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd0, 1'b0);
    O_HALT   = ov(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);

    reset = 1'b1; opcode = OP_ADD; bcond = 1'b0; halt_cond = 1'b0;
    mem_ready = 1'b1; mem_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset: outputs held at 0 even though IF with mem_ready=1 would drive strobes.
    step("rst", 3'd0, O_ZERO);
    chk("rst.wd_out", w_outv, O_ZERO);
    reset = 1'b0;

    // ADD, zero-wait: 0,1,2,4 then back to IF.
    opcode = OP_ADD;
    step("add.if", 3'd0, O_IF_R);
    step("add.id", 3'd1, O_ID);
    step("add.ex", 3'd2, O_EX_R);
    step("add.wb", 3'd4, O_WB_A);

    // LOAD with 3 wait cycles in MEM: 8 cycles total.
    opcode = OP_LOAD;
    step("ld.if", 3'd0, O_IF_R);
    step("ld.id", 3'd1, O_ID);
    step("ld.ex", 3'd2, O_EX_M);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("ld.memwait", 3'd3, O_MEM_L);
    mem_ready = 1'b1;
    step("ld.memrdy", 3'd3, O_MEM_L);
    step("ld.wb", 3'd4, O_WB_L);

    // ADDI with a 2-cycle fetch stall.
    opcode = OP_ADDI;
    mem_ready = 1'b0;
    step("addi.ifwait", 3'd0, O_IF_W);
    step("addi.ifwait", 3'd0, O_IF_W);
    mem_ready = 1'b1;
    step("addi.if", 3'd0, O_IF_R);
    step("addi.id", 3'd1, O_ID);
    step("addi.ex", 3'd2, O_EX_I);
    step("addi.wb", 3'd4, O_WB_A);

    // BEQ taken then not taken.
    opcode = OP_BR; bcond = 1'b1;
    step("beqt.if", 3'd0, O_IF_R);
    step("beqt.id", 3'd1, O_ID);
    step("beqt.ex", 3'd2, O_BR_T);
    bcond = 1'b0;
    step("beqn.if", 3'd0, O_IF_R);
    step("beqn.id", 3'd1, O_ID);
    step("beqn.ex", 3'd2, O_BR_N);

    // JAL and JALR.
    opcode = OP_JAL;
    step("jal.if", 3'd0, O_IF_R);
    step("jal.id", 3'd1, O_ID);
    step("jal.ex", 3'd2, O_JAL);
    opcode = OP_JALR;
    step("jalr.if", 3'd0, O_IF_R);
    step("jalr.id", 3'd1, O_ID);
    step("jalr.ex", 3'd2, O_JALR);

    // Unknown opcode retires as a 2-cycle NOP.
    opcode = OP_LUI;
    step("lui.if", 3'd0, O_IF_R);
    step("lui.id", 3'd1, O_NOP);

    // STORE, zero-wait: 4 cycles.
    opcode = OP_STORE;
    step("st.if", 3'd0, O_IF_R);
    step("st.id", 3'd1, O_ID);
    step("st.ex", 3'd2, O_EX_M);
    step("st.mem", 3'd3, O_MEM_SR);

    // ECALL with halt_cond=1.
    opcode = OP_ECALL; halt_cond = 1'b1;
    step("ecall.if", 3'd0, O_IF_R);
`ifdef ECALL_HALT_EN
    step("ecall.id", 3'd1, O_ID);
    for (int i = 0; i < 100; i++) step("ecall.halt", 3'd5, O_HALT);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`else
    step("ecall.id", 3'd1, O_NOP);
`endif
    halt_cond = 1'b0;

    // STORE waiting in MEM, then reset: strobes drop at once, state back to IF.
    opcode = OP_STORE;
    step("st2.if", 3'd0, O_IF_R);
    step("st2.id", 3'd1, O_ID);
    step("st2.ex", 3'd2, O_EX_M);
    mem_ready = 1'b0;
    step("st2.memwait", 3'd3, O_MEM_SW);
    #1;
    chk("st2.prereset", outv, O_MEM_SW);
    reset = 1'b1;
    #1;
    chk("st2.rst.out", outv, O_ZERO);
    chk("st2.rst.state", {13'd0, state}, 16'd0);

    // Watchdog: MEM_TIMEOUT=5, memory stuck not-ready.
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wd.if.state", {13'd0, w_state}, 16'd0);
      chk("wd.if.out", w_outv, O_IF_W);
      @(posedge clk); #1;
    end
    #1;
    chk("wd.halt.state", {13'd0, w_state}, 16'd5);
    chk("wd.halt.out", w_outv, O_HALT);
    chk("nowd.state", {13'd0, state}, 16'd0);
    @(posedge clk); #1;
    chk("wd.halt.hold", {13'd0, w_state}, 16'd5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
